wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage directly downstream of the ALU.
- Merges the ALU result stream, which has no backpressure, with the load/store-unit result stream (valid/ready) onto the single integer register-file write port.
- LSU results are buffered in a FIFO. ALU results take priority, with a one-entry hold register and a starvation guard so LSU writes cannot starve.
- Also provides a retire counter and a stall request to issue logic.

Parameters:
- XLEN, 64, data width.
- LSU_DEPTH, 4, LSU FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 8, cycles an LSU head may wait before being forced through.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alu_wb_vld  in  1  ALU result valid; always accepted
- alu_wb_addr  in  5  ALU destination register
- alu_wb_data  in  XLEN  ALU result
- lsu_wb_vld  in  1  LSU result valid
- lsu_wb_rdy  out  1  FIFO not full
- lsu_wb_addr  in  5  LSU destination register
- lsu_wb_data  in  XLEN  LSU result
- rf_wen  out  1  register-file write enable (registered)
- rf_waddr  out  5  write address (registered)
- rf_wdata  out  XLEN  write data (registered)
- wb_stall  out  1  request to stop issuing ALU ops
- wb_busy  out  1  hold occupied or FIFO non-empty
- wb_retire_cnt  out  64  writeback events since reset

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset: while rst=1, on the next edge:
  - FIFO is emptied, hold is cleared, starve_cnt=0, wb_retire_cnt=0.
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - lsu_wb_rdy=0, wb_stall=0, wb_busy=0.
  - Reset mid-operation discards all buffered results without writing them.
- LSU push: occurs when lsu_wb_vld & lsu_wb_rdy. lsu_wb_rdy = ~full, driven from registered count.
  - A push into a full FIFO cannot occur.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pointers wrap modulo LSU_DEPTH.
  - A pushed entry is eligible for selection no earlier than the next cycle.
- Source flags each cycle: H = hold valid, A = alu_wb_vld, L = FIFO non-empty, S = (starve_cnt ≥ STARVE_LIMIT) & L.
- Selection, in priority order:
  1. S & ~(H & A): write FIFO head and pop. If A, hold ← ALU result. If H, hold is retained.
  2. Else if H: write hold. Then hold ← ALU result if A, else hold is cleared.
  3. Else if A: write ALU result.
  4. Else if L: write FIFO head and pop.
  5. Else: no write.
- Output register:
  - The selected entry is registered into rf_waddr/rf_wdata the next cycle.
  - rf_wen = selected & (addr ≠ 0). A destination of x0 is consumed and counted, but rf_wen=0.
  - On a no-write cycle, rf_wen=0 and rf_waddr/rf_wdata hold their previous values.
- Latency:
  - ALU with no hold and no starvation: alu_wb_vld in cycle N gives rf_wen in N+1.
  - LSU into an empty FIFO with A=0: push in N gives rf_wen in N+2.
- starve_cnt:
  - Cleared when the FIFO is empty or the head is written.
  - Otherwise increments each cycle the head waits, saturating at STARVE_LIMIT.
- wb_stall = S, combinational from registered state. Issue logic stops new ALU issue while wb_stall=1; results already in flight still arrive and are absorbed by the hold register.
- wb_busy = H | L.
- wb_retire_cnt increments by 1 for every selected entry, including x0 writes, and wraps at 2^64.
- Ordering: no WAW hazard exists between in-flight ALU and LSU results, because the upstream scoreboard guarantees it. Write order between the two sources is therefore unconstrained.

Test Plan:
1. Reset then single ALU result: alu_wb_vld=1, addr=5, data=0x1234 in cycle 1 → cycle 2 shows rf_wen=1, rf_waddr=5, rf_wdata=0x1234, and wb_retire_cnt=1.
2. x0 suppression: ALU result to addr 0, data 0xFFFF → rf_wen stays 0 and wb_retire_cnt increments.
3. Conflict: ALU (r3=7) and LSU (r4=9) in the same cycle, then idle → r3 is written at +1 and r4 at +2. The FIFO count never exceeds 1 and lsu_wb_rdy stays 1.
4. FIFO full: ALU valid continuously while the LSU pushes 5 loads → lsu_wb_rdy drops after the 4th accepted push. No data is lost, and all 4 loads are written in push order once the ALU stops.
5. Starvation with STARVE_LIMIT=8: ALU valid every cycle while 1 load is buffered → wb_stall rises after 8 waiting cycles. Then:
   - The load is written ahead of the concurrent ALU result, which moves into hold.
   - When the ALU stops, hold is written the next cycle.
   - wb_stall falls once the FIFO empties.
6. Reset mid-operation: assert rst with 3 loads in the FIFO and hold occupied → the next cycle shows rf_wen=0, wb_busy=0, wb_retire_cnt=0, and the discarded entries are never written.

Source files
------------

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Writeback arbiter that sits directly after the ALU. It merges two result
// streams onto the single integer register-file write port:
//   * the ALU result stream, which has no backpressure and is always accepted;
//   * the LSU result stream (valid/ready), which is buffered in a small FIFO.
//
// ALU results normally win. A one-entry hold register absorbs an ALU result
// that arrives while the FIFO head is being forced through by the starvation
// guard, so ALU results are never dropped. The starvation guard forces the
// FIFO head out once it has waited STARVE_LIMIT cycles, and raises wb_stall
// so issue logic stops sending new ALU ops while that happens.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   alu_wb_*        ALU result (vld/addr/data), always accepted
//   lsu_wb_vld/rdy  LSU result handshake; rdy = FIFO not full
//   lsu_wb_addr/data LSU result payload
//   rf_wen/waddr/wdata  registered register-file write port
//   wb_stall        request to issue logic to stop issuing ALU ops
//   wb_busy         hold register occupied or FIFO non-empty
//   wb_retire_cnt   number of writeback events since reset (x0 included)
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int XLEN         = 64,
  parameter int LSU_DEPTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  // ALU result stream
  input  logic            alu_wb_vld,
  input  logic [4:0]      alu_wb_addr,
  input  logic [XLEN-1:0] alu_wb_data,
  // LSU result stream
  input  logic            lsu_wb_vld,
  output logic            lsu_wb_rdy,
  input  logic [4:0]      lsu_wb_addr,
  input  logic [XLEN-1:0] lsu_wb_data,
  // Register-file write port
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  // Status
  output logic            wb_stall,
  output logic            wb_busy,
  output logic [63:0]     wb_retire_cnt
);

  localparam int PTR_W = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(LSU_DEPTH);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [4:0]      fifo_addr [LSU_DEPTH];
  logic [XLEN-1:0] fifo_data [LSU_DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic             hold_vld_reg;
  logic [4:0]       hold_addr_reg;
  logic [XLEN-1:0]  hold_data_reg;

  logic [STV_W-1:0] starve_cnt_reg;

  logic             rf_wen_reg;
  logic [4:0]       rf_waddr_reg;
  logic [XLEN-1:0]  rf_wdata_reg;
  logic [63:0]      retire_cnt_reg;

  // ---------------------------------------------------------------------------
  // Source flags, all derived from registered state plus the live ALU valid
  // ---------------------------------------------------------------------------
  logic            fifo_full;
  logic            fifo_nempty;
  logic            starve;
  logic            push;
  logic [4:0]      head_addr;
  logic [XLEN-1:0] head_data;

  assign fifo_full   = (count_reg == FULL_CNT);
  assign fifo_nempty = (count_reg != '0);
  // starve_cnt saturates at the limit, but >= keeps the intent obvious
  assign starve      = (starve_cnt_reg >= STARVE_MAX) & fifo_nempty;

  // Ready comes from the registered count only, so it never depends on
  // this cycle's pop. It is also held low while reset is asserted.
  assign lsu_wb_rdy  = ~fifo_full & ~rst;
  assign push        = lsu_wb_vld & lsu_wb_rdy;

  // Asynchronous head read: a pushed entry must be selectable on the very
  // next cycle, which a registered read port could not provide.
  assign head_addr   = fifo_addr[rd_ptr_reg];
  assign head_data   = fifo_data[rd_ptr_reg];

  // ---------------------------------------------------------------------------
  // Selection
  // ---------------------------------------------------------------------------
  logic            sel_vld;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;
  logic            pop;
  logic            hold_load;   // capture the ALU result into hold
  logic            hold_clear;  // hold was written out and nothing replaces it

  always_comb begin
    sel_vld    = 1'b0;
    sel_addr   = '0;
    sel_data   = '0;
    pop        = 1'b0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;

    if (starve && !(hold_vld_reg && alu_wb_vld)) begin
      // Forced FIFO write. The concurrent ALU result (if any) parks in hold;
      // an occupied hold is simply kept. Both cannot happen together because
      // of the H&A exclusion above, so hold never overflows.
      sel_vld   = 1'b1;
      sel_addr  = head_addr;
      sel_data  = head_data;
      pop       = 1'b1;
      hold_load = alu_wb_vld;
    end else if (hold_vld_reg) begin
      sel_vld    = 1'b1;
      sel_addr   = hold_addr_reg;
      sel_data   = hold_data_reg;
      hold_load  = alu_wb_vld;
      hold_clear = ~alu_wb_vld;
    end else if (alu_wb_vld) begin
      sel_vld  = 1'b1;
      sel_addr = alu_wb_addr;
      sel_data = alu_wb_data;
    end else if (fifo_nempty) begin
      sel_vld  = 1'b1;
      sel_addr = head_addr;
      sel_data = head_data;
      pop      = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage (no reset needed: occupancy is tracked by the pointers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_reg] <= lsu_wb_addr;
      fifo_data[wr_ptr_reg] <= lsu_wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Control state, hold register, starvation counter and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      hold_vld_reg   <= 1'b0;
      hold_addr_reg  <= '0;
      hold_data_reg  <= '0;
      starve_cnt_reg <= '0;
      rf_wen_reg     <= 1'b0;
      rf_waddr_reg   <= '0;
      rf_wdata_reg   <= '0;
      retire_cnt_reg <= '0;
    end else begin
      // Pointers wrap naturally because LSU_DEPTH is a power of two
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      if (hold_load) begin
        hold_vld_reg  <= 1'b1;
        hold_addr_reg <= alu_wb_addr;
        hold_data_reg <= alu_wb_data;
      end else if (hold_clear) begin
        hold_vld_reg  <= 1'b0;
      end

      // Counts cycles the current head has waited; reset whenever the head
      // leaves or there is no head at all.
      if (!fifo_nempty || pop) begin
        starve_cnt_reg <= '0;
      end else if (starve_cnt_reg < STARVE_MAX) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end

      // A write to x0 still updates address/data and is counted as retired,
      // it just does not assert the register-file write enable.
      if (sel_vld) begin
        rf_wen_reg     <= (sel_addr != 5'd0);
        rf_waddr_reg   <= sel_addr;
        rf_wdata_reg   <= sel_data;
        retire_cnt_reg <= retire_cnt_reg + 64'd1;
      end else begin
        rf_wen_reg     <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rf_wen        = rf_wen_reg;
  assign rf_waddr      = rf_waddr_reg;
  assign rf_wdata      = rf_wdata_reg;
  assign wb_stall      = starve;
  assign wb_busy       = hold_vld_reg | fifo_nempty;
  assign wb_retire_cnt = retire_cnt_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed scenarios followed by a randomized phase. A behavioural model
// (queue for the LSU buffer, a hold slot, a wait counter) predicts every
// output cycle by cycle from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_wb_vld;
  logic [4:0]      alu_wb_addr;
  logic [XLEN-1:0] alu_wb_data;
  logic            lsu_wb_vld;
  logic            lsu_wb_rdy;
  logic [4:0]      lsu_wb_addr;
  logic [XLEN-1:0] lsu_wb_data;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            wb_stall;
  logic            wb_busy;
  logic [63:0]     wb_retire_cnt;

  wb_arbiter #(
    .XLEN(XLEN),
    .LSU_DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alu_wb_vld(alu_wb_vld),
    .alu_wb_addr(alu_wb_addr),
    .alu_wb_data(alu_wb_data),
    .lsu_wb_vld(lsu_wb_vld),
    .lsu_wb_rdy(lsu_wb_rdy),
    .lsu_wb_addr(lsu_wb_addr),
    .lsu_wb_data(lsu_wb_data),
    .rf_wen(rf_wen),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .wb_stall(wb_stall),
    .wb_busy(wb_busy),
    .wb_retire_cnt(wb_retire_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } wb_t;

  // Reference model state
  wb_t         m_q[$];
  bit          m_hold_v;
  wb_t         m_hold;
  int          m_starve;
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata;
  logic [63:0] m_retire;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_hold_v = 1'b0;
    m_hold   = '0;
    m_starve = 0;
    m_wen    = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    m_retire = '0;
  endtask

  // Starts at posedge+1, ends at the following posedge+1.
  task automatic step(input bit av, input logic [4:0] aa, input logic [63:0] ad,
                      input bit lv, input logic [4:0] la, input logic [63:0] ld);
    bit  h, a, l, s, rdy, psh, pop, sel;
    wb_t w;
    alu_wb_vld  = av;
    alu_wb_addr = aa;
    alu_wb_data = ad;
    lsu_wb_vld  = lv;
    lsu_wb_addr = la;
    lsu_wb_data = ld;
    #1;
    rdy = (m_q.size() < DEPTH);
    h   = m_hold_v;
    a   = av;
    l   = (m_q.size() > 0);
    s   = (m_starve >= LIMIT) && l;
    chk("lsu_rdy", lsu_wb_rdy, rdy);
    chk("stall", wb_stall, s);
    chk("busy", wb_busy, h || l);
    psh = lv && rdy;
    sel = 1'b0;
    pop = 1'b0;
    w   = '0;
    if (s && !(h && a)) begin
      w = m_q[0]; sel = 1'b1; pop = 1'b1;
      if (a) begin
        m_hold_v = 1'b1;
        m_hold   = '{aa, ad};
      end
    end else if (h) begin
      w = m_hold; sel = 1'b1;
      if (a) m_hold = '{aa, ad};
      else   m_hold_v = 1'b0;
    end else if (a) begin
      w = '{aa, ad}; sel = 1'b1;
    end else if (l) begin
      w = m_q[0]; sel = 1'b1; pop = 1'b1;
    end
    if (!l || pop) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    if (pop) void'(m_q.pop_front());
    if (psh) m_q.push_back('{la, ld});
    m_wen = sel && (w.addr != 5'd0);
    if (sel) begin
      m_waddr = w.addr;
      m_wdata = w.data;
      m_retire++;
    end
    @(posedge clk);
    #1;
    chk("rf_wen", rf_wen, m_wen);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("retire", wb_retire_cnt, m_retire);
    $display("[TB] t=%0t alu=%0b/%0d lsu=%0b/%0d push=%0b -> wen=%0b waddr=%0d wdata=%h retire=%0d",
             $time, av, aa, lv, la, psh, rf_wen, rf_waddr, rf_wdata, wb_retire_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  // Ends at posedge+1 with reset released.
  task automatic do_reset();
    rst         = 1'b1;
    alu_wb_vld  = 1'b0;
    alu_wb_addr = '0;
    alu_wb_data = '0;
    lsu_wb_vld  = 1'b0;
    lsu_wb_addr = '0;
    lsu_wb_data = '0;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_wen", rf_wen, 1'b0);
    chk("rst_waddr", rf_waddr, 5'd0);
    chk("rst_wdata", rf_wdata, 64'd0);
    chk("rst_rdy", lsu_wb_rdy, 1'b0);
    chk("rst_stall", wb_stall, 1'b0);
    chk("rst_busy", wb_busy, 1'b0);
    chk("rst_retire", wb_retire_cnt, 64'd0);
    rst = 1'b0;
    $display("[TB] t=%0t reset applied", $time);
  endtask

  initial begin
    bit av, lv;
    model_reset();
    do_reset();

    // 1: single ALU result, one-cycle latency
    step(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);
    chk("t1_wen", rf_wen, 1'b1);
    chk("t1_waddr", rf_waddr, 5'd5);
    chk("t1_wdata", rf_wdata, 64'h1234);
    chk("t1_retire", wb_retire_cnt, 64'd1);

    // 2: x0 destination is counted but not written
    step(1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 64'd0);
    chk("t2_wen", rf_wen, 1'b0);
    chk("t2_retire", wb_retire_cnt, 64'd2);

    // 3: simultaneous ALU and LSU
    step(1'b1, 5'd3, 64'd7, 1'b1, 5'd4, 64'd9);
    chk("t3_first", rf_waddr, 5'd3);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    chk("t3_second", rf_waddr, 5'd4);
    chk("t3_second_wen", rf_wen, 1'b1);
    chk("t3_second_data", rf_wdata, 64'd9);
    idle(2);

    // 4: fill the FIFO under continuous ALU traffic
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'(1 + i), 64'(100 + i), 1'b1, 5'(10 + i), 64'(200 + i));
    chk("t4_full_rdy", lsu_wb_rdy, 1'b0);
    step(1'b1, 5'd9, 64'd109, 1'b1, 5'd14, 64'd204);
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd14, 64'd204);
    chk("t4_head_first", rf_waddr, 5'd10);
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd14, 64'd204);
    idle(6);
    chk("t4_drained", wb_busy, 1'b0);

    // 5: starvation guard
    step(1'b1, 5'd15, 64'd300, 1'b1, 5'd7, 64'd77);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 5'(15 + i), 64'(300 + i), 1'b0, 5'd0, 64'd0);
      if (i == 7) chk("t5_stall_low", wb_stall, 1'b0);
    end
    chk("t5_stall_high", wb_stall, 1'b1);
    step(1'b1, 5'd20, 64'd320, 1'b0, 5'd0, 64'd0);
    chk("t5_load_first", rf_waddr, 5'd7);
    chk("t5_stall_fall", wb_stall, 1'b0);
    step(1'b1, 5'd21, 64'd321, 1'b0, 5'd0, 64'd0);
    chk("t5_hold_written", rf_waddr, 5'd20);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    chk("t5_last_hold", rf_waddr, 5'd21);
    idle(1);
    chk("t5_idle_busy", wb_busy, 1'b0);

    // 6: reset with buffered loads and an occupied hold
    step(1'b1, 5'd1, 64'd400, 1'b1, 5'd25, 64'd500);
    for (int i = 0; i < 8; i++) step(1'b1, 5'd2, 64'(401 + i), 1'b0, 5'd0, 64'd0);
    step(1'b1, 5'd3, 64'd410, 1'b1, 5'd26, 64'd501);
    step(1'b1, 5'd4, 64'd411, 1'b1, 5'd27, 64'd502);
    step(1'b1, 5'd5, 64'd412, 1'b1, 5'd28, 64'd503);
    chk("t6_busy_before", wb_busy, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      chk("t6_no_write", rf_wen, 1'b0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      av = ($urandom_range(0, 99) < 60);
      lv = ($urandom_range(0, 99) < 50);
      step(av, 5'($urandom_range(0, 31)), {$urandom(), $urandom()},
           lv, 5'($urandom_range(0, 31)), {$urandom(), $urandom()});
    end
    idle(12);
    chk("final_busy", wb_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
